cs_store_loader: RTL and testbench
==================================

Name: cs_store_loader

Overview:
- Serial loader that writes packed 71-bit control words into the microcode control store.
- It is the writer side of the control-word path. It accepts a byte stream from the debug/boot loader over a valid/ready handshake and reassembles each 71-bit word, least-significant byte first.
- Each completed word is issued as a single-cycle write strobe to the control store at an auto-incrementing address.
- Downstream, the control store feeds the control-word field decoder in the CPU datapath.

Parameters:
CS_WIDTH, 71, control word width in bits; fixed by the decoder field map.
ADDR_WIDTH, 9, control store address width (512 entries).
BYTES_PER_WORD, 9, equals ceil(CS_WIDTH/8); byte 8 carries bits [70:64].

Ports:
clock  input  1  system clock; all state changes on rising edge.
nreset  input  1  synchronous active-low reset.
start  input  1  one-cycle pulse that begins a load; ignored unless in IDLE.
start_addr  input  ADDR_WIDTH  first control store address; sampled on start.
word_count  input  ADDR_WIDTH+1  number of words to load (0..512); sampled on start.
abort  input  1  forces return to IDLE from any state; clears error.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle.
cs_wr_en  output  1  control store write strobe, one cycle per word.
cs_wr_addr  output  ADDR_WIDTH  write address; valid while cs_wr_en=1.
cs_wr_data  output  CS_WIDTH  assembled word; valid while cs_wr_en=1.
busy  output  1  high in COLLECT, WRITE and ERROR.
done  output  1  one-cycle pulse when the last word has been written.
error  output  1  sticky; high in ERROR.

Behaviour:
- Reset (nreset=0 at a clock edge): state=IDLE. in_ready, cs_wr_en, busy, done and error are 0. cs_wr_addr, cs_wr_data, byte index, address counter and remaining counter are 0. Reset is legal in any state; any partial word is discarded.
- A byte is accepted when in_valid && in_ready at the clock edge. No byte is taken otherwise, and in_valid gaps are legal at any point.
- Byte k (0..8) is stored into bits [8k+7:8k]. Byte 8 supplies bits [70:64]; its bit 7 must be 0.
- IDLE:
  - in_ready=0.
  - start with word_count=0: done=1 on the next cycle, state stays IDLE, no write.
  - start with word_count>0: latch address counter=start_addr, remaining=word_count, byte index=0; go to COLLECT.
- COLLECT:
  - in_ready=1. Each accepted byte is stored and the byte index is incremented.
  - On acceptance of byte 8 with in_data[7]=0: go to WRITE.
  - On acceptance of byte 8 with in_data[7]=1: go to ERROR; no write occurs.
- WRITE (exactly one cycle):
  - cs_wr_en=1, cs_wr_addr=address counter, cs_wr_data=assembled word, in_ready=0.
  - At the edge ending WRITE: address counter +1, wrapping modulo 2^ADDR_WIDTH (0x1FF -> 0x000); remaining -1; byte index=0.
  - If remaining was 1: go to IDLE and pulse done in the cycle after WRITE. Otherwise go to COLLECT.
- ERROR: in_ready=0 and error=1. The block stays in ERROR until abort or reset; start is ignored.
- abort has priority over every other event in the same cycle, except reset. Next state is IDLE, error=0, no write, no done pulse, and a partial word is discarded.
- start while not in IDLE is ignored.
- Throughput: at least 10 cycles per word (9 accepts + 1 WRITE).
- cs_wr_data and cs_wr_addr hold their last values when cs_wr_en=0. Consumers must qualify them with cs_wr_en.
- Registers: all outputs are registered; in_ready is a decode of registered state; no combinational path from in_* to cs_wr_*.

Test Plan:
- Single word: start_addr=0x010, word_count=1, bytes 01,02,03,04,05,06,07,08,7F with in_valid held high.
  - in_ready high for 9 cycles, then one cs_wr_en with addr 0x010 and data 71'h7F_0807060504030201.
  - done pulses on the next cycle; busy falls with done.
- Backpressure: same word with in_valid low on alternate cycles.
  - Identical write data, occurring only after the 9th accepted byte; no duplicated or dropped bytes.
- Format error: byte 8 = 0x80.
  - No cs_wr_en; error=1, in_ready=0, busy=1; a start pulse is ignored.
  - abort -> next cycle error=0, busy=0, IDLE; a fresh load then succeeds.
- Address wrap: start_addr=0x1FF, word_count=2, two valid words.
  - Writes at 0x1FF then 0x000; done only after the second write.
- Reset mid-word: after 5 accepted bytes, nreset=0 for one cycle.
  - All outputs 0 and no write.
  - A new start_addr=0x020, word_count=1 load writes exactly the 9 new bytes to 0x020.
- Zero count: start with word_count=0.
  - done=1 next cycle, no cs_wr_en, busy remains 0, in_ready remains 0.

Source files
------------

// File: rtl/cs_store_loader.sv
// -----------------------------------------------------------------------------
// cs_store_loader
//
// Writer side of the microcode control-word path. Takes a byte stream from the
// debug/boot loader over a valid/ready handshake and packs each group of
// BYTES_PER_WORD bytes, least-significant byte first, into one CS_WIDTH-bit
// control word. Each finished word goes to the control store as a single-cycle
// write at an auto-incrementing address.
//
// The last byte of a word carries only the top CS_WIDTH - 8*(BYTES_PER_WORD-1)
// bits. Its unused upper bits must be zero. If they are not, the stream is
// considered corrupt: the word is not written and the block parks in ERROR
// until abort or reset.
//
// Ports
//   clock        system clock, rising edge
//   nreset       synchronous active-low reset
//   start        one-cycle load request, honoured only in IDLE
//   start_addr   first control store address (sampled on start)
//   word_count   number of words to load, 0..2^ADDR_WIDTH (sampled on start)
//   abort        return to IDLE from any state, clears error
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     loader takes a byte this cycle (decode of state)
//   cs_wr_en     control store write strobe, one cycle per word
//   cs_wr_addr   write address, qualify with cs_wr_en
//   cs_wr_data   assembled word, qualify with cs_wr_en
//   busy         load in progress (COLLECT, WRITE, ERROR)
//   done         one-cycle pulse after the final write (or after a zero-count start)
//   error        high while parked in ERROR
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; nothing accepted from the stream
// COLLECT | accepting bytes of the current word
// WRITE   | one-cycle control store write of the assembled word
// ERROR   | malformed final byte seen; wait for abort or reset
// -----------------------------------------------------------------------------
module cs_store_loader #(
    parameter int CS_WIDTH       = 71,
    parameter int ADDR_WIDTH     = 9,
    parameter int BYTES_PER_WORD = 9
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  cs_wr_en,
    output logic [ADDR_WIDTH-1:0] cs_wr_addr,
    output logic [CS_WIDTH-1:0]   cs_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_ERROR   = 2'd3;

    // Bytes 0..BYTES_PER_WORD-2 are buffered; the final byte goes straight
    // into cs_wr_data together with the buffer, so no extra cycle is needed.
    localparam int LOW_WIDTH = 8 * (BYTES_PER_WORD - 1);
    localparam int TOP_BITS  = CS_WIDTH - LOW_WIDTH;

    localparam logic [3:0]            LAST_IDX = 4'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE  = (ADDR_WIDTH + 1)'(1);

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [3:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   remaining;
    logic [LOW_WIDTH-1:0]  word_buf;

    logic accept;
    logic last_byte;
    logic fmt_bad;
    logic start_zero;
    logic start_load;
    logic last_write;

    assign in_ready = (state == S_COLLECT);

    always_comb begin
        accept     = (state == S_COLLECT) && in_valid;
        last_byte  = accept && (byte_idx == LAST_IDX);
        fmt_bad    = |in_data[7:TOP_BITS];
        start_zero = (state == S_IDLE) && start && (word_count == '0);
        start_load = (state == S_IDLE) && start && (word_count != '0);
        last_write = (state == S_WRITE) && (remaining == REM_ONE);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_load) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (last_byte) begin
                    state_nxt = fmt_bad ? S_ERROR : S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = last_write ? S_IDLE : S_COLLECT;
            end
            S_ERROR: begin
                state_nxt = S_ERROR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // abort outranks everything except reset
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    // Status outputs are registered from the next-state decode so they line
    // up with the state they describe. A consequence is that cs_wr_en is
    // already committed once WRITE is entered: abort in the cycle that
    // accepts the final byte suppresses the write, abort during WRITE
    // itself only cancels the counter update and any done pulse.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state      <= S_IDLE;
            byte_idx   <= '0;
            addr_cnt   <= '0;
            remaining  <= '0;
            word_buf   <= '0;
            cs_wr_en   <= 1'b0;
            cs_wr_addr <= '0;
            cs_wr_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            error    <= (state_nxt == S_ERROR);
            cs_wr_en <= (state_nxt == S_WRITE);
            done     <= !abort && (start_zero || last_write);

            if (abort) begin
                byte_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_load) begin
                            addr_cnt  <= start_addr;
                            remaining <= word_count;
                            byte_idx  <= '0;
                        end
                    end
                    S_COLLECT: begin
                        if (accept) begin
                            byte_idx <= byte_idx + 4'd1;
                            if (!last_byte) begin
                                word_buf[{byte_idx[2:0], 3'b000} +: 8] <= in_data;
                            end else if (!fmt_bad) begin
                                cs_wr_addr <= addr_cnt;
                                cs_wr_data <= {in_data[TOP_BITS-1:0], word_buf};
                            end
                        end
                    end
                    S_WRITE: begin
                        addr_cnt  <= addr_cnt + ADDR_ONE;
                        remaining <= remaining - REM_ONE;
                        byte_idx  <= '0;
                    end
                    default: begin
                        byte_idx <= byte_idx;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cs_store_loader.sv
// -----------------------------------------------------------------------------
// tb_cs_store_loader
//
// Self-checking bench for cs_store_loader. A table of load scenarios (start
// address, count, handshake gap style, corrupted word) is applied in a loop,
// followed by randomized loads. Expected writes come from a transaction-level
// model: each word is the little-endian sum of its random bytes, written at
// (start_addr + n) mod 512. Hand-written sequences cover exact cycle timing,
// reset mid-word, abort mid-word and the zero-count start.
// -----------------------------------------------------------------------------
module tb_cs_store_loader;

    localparam int CS_WIDTH   = 71;
    localparam int ADDR_WIDTH = 9;
    localparam int BPW        = 9;

    logic                  clock = 1'b0;
    logic                  nreset = 1'b0;
    logic                  start = 1'b0;
    logic [ADDR_WIDTH-1:0] start_addr = '0;
    logic [ADDR_WIDTH:0]   word_count = '0;
    logic                  abort = 1'b0;
    logic [7:0]            in_data = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  cs_wr_en;
    logic [ADDR_WIDTH-1:0] cs_wr_addr;
    logic [CS_WIDTH-1:0]   cs_wr_data;
    logic                  busy;
    logic                  done;
    logic                  error;

    cs_store_loader #(
        .CS_WIDTH      (CS_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BYTES_PER_WORD(BPW)
    ) dut (
        .clock     (clock),
        .nreset    (nreset),
        .start     (start),
        .start_addr(start_addr),
        .word_count(word_count),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cs_wr_en  (cs_wr_en),
        .cs_wr_addr(cs_wr_addr),
        .cs_wr_data(cs_wr_data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [CS_WIDTH-1:0]   data;
    } wr_t;

    typedef struct {
        logic [ADDR_WIDTH-1:0] sa;
        logic [ADDR_WIDTH:0]   wc;
        int                    gap;      // 0 continuous, 1 alternate, 2 random
        int                    bad_idx;  // word with a corrupt final byte, -1 none
        int                    exp_writes;
        logic [ADDR_WIDTH-1:0] exp_last_addr;
        logic                  exp_error;
        int                    exp_done;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Monitor: sampled on the falling edge, away from the active edge.
    wr_t got_q[$];
    int  done_cnt = 0;
    always @(negedge clock) begin
        if (cs_wr_en) got_q.push_back('{addr: cs_wr_addr, data: cs_wr_data});
        if (done) done_cnt++;
    end

    logic [7:0] byte_q[$];
    wr_t        exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_WIDTH-1:0] sa, input logic [ADDR_WIDTH:0] wc);
        start_addr = sa;
        word_count = wc;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Reference model: random bytes per word, word = sum of byte_k << 8k.
    task automatic build_load(input logic [ADDR_WIDTH-1:0] sa, input int wc, input int bad_idx);
        logic [7:0]          b[BPW];
        logic [CS_WIDTH-1:0] word;
        byte_q.delete();
        exp_q.delete();
        for (int w = 0; w < wc; w++) begin
            word = '0;
            for (int k = 0; k < BPW - 1; k++) b[k] = 8'($urandom_range(0, 255));
            b[BPW-1] = 8'($urandom_range(0, 127));
            if (w == bad_idx) b[BPW-1] = b[BPW-1] | 8'h80;
            for (int k = 0; k < BPW; k++) begin
                byte_q.push_back(b[k]);
                word = word | (CS_WIDTH'(b[k]) << (8 * k));
            end
            if (w == bad_idx) break;
            exp_q.push_back('{addr: ADDR_WIDTH'((int'(sa) + w) % 512), data: word});
        end
    endtask

    task automatic feed(input int gap);
        int   sent;
        int   cyc;
        logic acc;
        sent = 0;
        cyc = 0;
        while (sent < byte_q.size() && cyc < 4000) begin
            in_data = byte_q[sent];
            case (gap)
                0:       in_valid = 1'b1;
                1:       in_valid = ((cyc % 2) == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            acc = in_valid && in_ready;
            step();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("feed_accepted", 128'(sent), 128'(byte_q.size()));
    endtask

    task automatic run_vec(input vec_t v);
        int wr_base;
        int done_base;
        int n;
        build_load(v.sa, int'(v.wc), v.bad_idx);
        wr_base = got_q.size();
        done_base = done_cnt;
        pulse_start(v.sa, v.wc);
        feed(v.gap);
        n = 0;
        while (busy && !error && n < 50) begin
            step();
            n++;
        end
        step();
        chk("settle_timeout", 128'(n < 50), 128'(1));
        chk("wr_count", 128'(got_q.size() - wr_base), 128'(v.exp_writes));
        for (int i = 0; i < exp_q.size() && (wr_base + i) < got_q.size(); i++) begin
            chk("wr_addr", 128'(got_q[wr_base+i].addr), 128'(exp_q[i].addr));
            chk("wr_data", 128'(got_q[wr_base+i].data), 128'(exp_q[i].data));
        end
        if (v.exp_writes > 0 && got_q.size() > wr_base)
            chk("last_addr", 128'(got_q[got_q.size()-1].addr), 128'(v.exp_last_addr));
        chk("error", 128'(error), 128'(v.exp_error));
        chk("done_count", 128'(done_cnt - done_base), 128'(v.exp_done));
        if (v.exp_error) begin
            chk("err_busy", 128'(busy), 128'(1));
            chk("err_in_ready", 128'(in_ready), 128'(0));
            pulse_start(9'h000, 10'd1);
            step();
            chk("err_start_ignored", 128'({error, busy, in_ready}), 128'(3'b110));
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_clear", 128'({error, busy, in_ready}), 128'(3'b000));
            step();
            chk("abort_no_write", 128'(got_q.size() - wr_base), 128'(v.exp_writes));
            chk("abort_no_done", 128'(done_cnt - done_base), 128'(0));
        end else begin
            chk("idle_busy", 128'(busy), 128'(0));
        end
    endtask

    vec_t vecs[8];

    initial begin
        int   rdy_cycles;
        int   wr_base;
        int   done_base;
        vec_t v;
        logic [7:0] single[BPW];

        vecs[0] = '{9'h010, 10'd1, 0, -1, 1, 9'h010, 1'b0, 1};
        vecs[1] = '{9'h1FF, 10'd2, 0, -1, 2, 9'h000, 1'b0, 1};
        vecs[2] = '{9'h0A5, 10'd3, 1, -1, 3, 9'h0A7, 1'b0, 1};
        vecs[3] = '{9'h1FE, 10'd4, 2, -1, 4, 9'h001, 1'b0, 1};
        vecs[4] = '{9'h040, 10'd3, 2,  1, 1, 9'h040, 1'b1, 0};
        vecs[5] = '{9'h100, 10'd2, 1,  0, 0, 9'h000, 1'b1, 0};
        vecs[6] = '{9'h003, 10'd0, 0, -1, 0, 9'h000, 1'b0, 1};
        vecs[7] = '{9'h0C0, 10'd1, 1, -1, 1, 9'h0C0, 1'b0, 1};

        // Reset state
        nreset = 1'b0;
        step();
        step();
        chk("rst_flags", 128'({in_ready, cs_wr_en, busy, done, error}), 128'(5'b0));
        chk("rst_addr", 128'(cs_wr_addr), 128'(0));
        chk("rst_data", 128'(cs_wr_data), 128'(0));
        nreset = 1'b1;
        step();

        // Single word, exact timing, bytes 01..08,7F back to back
        single = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h7F};
        done_base = done_cnt;
        pulse_start(9'h010, 10'd1);
        rdy_cycles = 0;
        for (int i = 0; i < BPW; i++) begin
            in_data = single[i];
            in_valid = 1'b1;
            if (in_ready) rdy_cycles++;
            step();
        end
        in_valid = 1'b0;
        chk("sw_ready_cycles", 128'(rdy_cycles), 128'(9));
        chk("sw_wr_en", 128'({cs_wr_en, in_ready, busy, done}), 128'(4'b1010));
        chk("sw_addr", 128'(cs_wr_addr), 128'(9'h010));
        chk("sw_data", 128'(cs_wr_data), 128'(71'h7F_0807060504030201));
        step();
        chk("sw_done", 128'({cs_wr_en, in_ready, busy, done}), 128'(4'b0001));
        chk("sw_hold_data", 128'(cs_wr_data), 128'(71'h7F_0807060504030201));
        step();
        chk("sw_done_pulse", 128'(done), 128'(0));
        chk("sw_done_count", 128'(done_cnt - done_base), 128'(1));

        // Zero count
        wr_base = got_q.size();
        done_base = done_cnt;
        pulse_start(9'h055, 10'd0);
        chk("zc_done", 128'({done, busy, in_ready, cs_wr_en}), 128'(4'b1000));
        step();
        chk("zc_after", 128'({done, busy, in_ready}), 128'(3'b000));
        chk("zc_no_write", 128'(got_q.size() - wr_base), 128'(0));

        // Table-driven scenarios
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-word after 5 accepted bytes
        wr_base = got_q.size();
        pulse_start(9'h050, 10'd1);
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'hA0 + i);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        nreset = 1'b0;
        step();
        chk("mid_rst_flags", 128'({in_ready, cs_wr_en, busy, done, error}), 128'(5'b0));
        chk("mid_rst_addr", 128'(cs_wr_addr), 128'(0));
        chk("mid_rst_data", 128'(cs_wr_data), 128'(0));
        nreset = 1'b1;
        step();
        chk("mid_rst_no_write", 128'(got_q.size() - wr_base), 128'(0));
        run_vec('{9'h020, 10'd1, 0, -1, 1, 9'h020, 1'b0, 1});

        // Abort mid-word
        wr_base = got_q.size();
        done_base = done_cnt;
        pulse_start(9'h077, 10'd2);
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom_range(0, 255));
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("mid_abort_flags", 128'({busy, in_ready, error}), 128'(3'b000));
        step();
        chk("mid_abort_no_write", 128'(got_q.size() - wr_base), 128'(0));
        chk("mid_abort_no_done", 128'(done_cnt - done_base), 128'(0));

        // Randomized loads
        for (int r = 0; r < 6; r++) begin
            v.sa = 9'($urandom_range(0, 511));
            v.wc = 10'($urandom_range(1, 3));
            v.gap = $urandom_range(0, 2);
            v.bad_idx = -1;
            v.exp_writes = int'(v.wc);
            v.exp_last_addr = 9'((int'(v.sa) + int'(v.wc) - 1) % 512);
            v.exp_error = 1'b0;
            v.exp_done = 1;
            run_vec(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
